// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - MEM->WB payload layout and skid-stage state encoding
package mem_wb_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic              wb_memtoreg;
    logic              wb_regwrite;
    logic              ls_word;
  } mem_wb_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// rtl/mem_wb_skid_stage.sv - MEM->WB stage with 2-entry skid buffer and registered in_ready
// Optional stall-cycle counter enabled by MEM_WB_STALL_CNT_EN.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int PAYLOAD_W = 40,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           occupancy
`ifdef MEM_WB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt
`endif
);

  generate
    if (PAYLOAD_W < 1 || CNT_W < 1) begin : g_bad_param
      $error("mem_wb_skid_stage: PAYLOAD_W and CNT_W must be positive");
    end
  endgenerate

  skid_state_t          state;
  logic [PAYLOAD_W-1:0] m_data;
  logic [PAYLOAD_W-1:0] s_data;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_data  = m_data;

  // in_ready is updated together with state so upstream never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= EMPTY;
      m_data   <= '0;
      s_data   <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m_data <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            m_data <= in_data;
          end else if (in_xfer) begin
            s_data   <= in_data;
            state    <= SKID;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (out_xfer) begin
            m_data   <= s_data;
            state    <= FULL;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (state)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef MEM_WB_STALL_CNT_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr_n(rst),
    .inc  (out_valid & ~out_ready),
    .count(stall_cnt)
  );
`else
`endif

endmodule
